pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 5: number of pipeline stages; index 0 is the youngest stage (IF), NSTAGE-1 is the oldest (WB).
REQ-002 SHALL have parameter NSTART, default 2: number of independent stall-release (start) sources.
REQ-003 SHALL have parameter TIMEOUT, default 255: hold-cycle count at which the watchdog fires.
REQ-004 SHALL have parameter FLUSH_CYC, default 1: flush duration in cycles, minimum 1.
REQ-005 SHALL have parameter SW = clog2(NSTAGE), CW = clog2(TIMEOUT+1), both derived.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 stall_req  in  NSTAGE  bit i: stage i cannot advance this cycle.
REQ-009 stop_req  in  1  request a held stall of the whole pipeline.
REQ-010 start_req  in  NSTART  any bit set releases a held stall.
REQ-011 flush_req  in  1  discard younger stages (branch redirect/exception).
REQ-012 flush_stage  in  SW  stage raising the flush; valid when flush_req=1.
REQ-013 stall  out  NSTAGE  bit i: stage i holds its pipeline register.
REQ-014 bubble  out  NSTAGE  bit i: stage i loads a NOP this cycle.
REQ-015 flush  out  NSTAGE  bit i: stage i invalidates its contents.
REQ-016 state  out  2  current FSM state: RUN=0, HOLD=1, FLUSH=2.
REQ-017 hold_cnt  out  CW  cycles spent in HOLD, saturating.
REQ-018 timeout  out  1  watchdog flag.

Function
REQ-019 stall/bubble/flush SHALL be combinational from the registered state and the same-cycle inputs, with zero-cycle latency; state, hold_cnt, timeout and the internal counters SHALL be registered.
REQ-020 In RUN, with h = highest index where stall_req[h]=1, the block SHALL drive stall[j]=1 for all j<=h, and bubble[h+1]=1 when h+1<NSTAGE; with no request set, stall=0 and bubble=0.
REQ-021 In HOLD, the block SHALL drive stall all-ones, bubble=0, flush=0, regardless of stall_req.
REQ-022 In FLUSH, with latched stage f, the block SHALL drive flush[j]=1 for j<f, stall=0 and bubble=0; flush_req in the current cycle SHALL override the RUN-mode stall/bubble outputs in that same cycle.
REQ-023 Transition priority on each edge SHALL be: rst > flush_req > stop_req > start_req.
REQ-024 RUN->FLUSH on flush_req; RUN->HOLD on stop_req; start_req in RUN is ignored.
REQ-025 HOLD->FLUSH on flush_req; HOLD->RUN on any start_req bit; stop_req together with start_req in HOLD SHALL keep HOLD.
REQ-026 On entering FLUSH, the block SHALL latch flush_stage and load the flush counter with FLUSH_CYC-1, then exit after FLUSH_CYC cycles.
REQ-027 On a new flush_req while in FLUSH, the block SHALL latch max(current f, flush_stage) and reload the counter.
REQ-028 On stop_req while in FLUSH, the block SHALL set a pending bit; on FLUSH exit it goes to HOLD if the bit is pending, else to RUN; the pending bit clears on the exit.
REQ-029 hold_cnt SHALL be 0 outside HOLD, increment by 1 per HOLD cycle, and saturate at TIMEOUT with no wrap.
REQ-030 timeout SHALL be set on the edge where hold_cnt reaches TIMEOUT, remain set while in HOLD, and clear on leaving HOLD.

Reset
REQ-031 While rst=1, outputs SHALL be stall=0, bubble=0, flush=0 combinationally.
REQ-032 On a clk edge with rst=1, state=RUN, hold_cnt=0, timeout=0, latched f=0, flush counter=0 and pending stop=0, including mid-HOLD and mid-FLUSH.

Verification
REQ-033 RUN, stall_req=5'b00100 -> stall=5'b00111, bubble=5'b01000, flush=0 same cycle; stall_req=5'b10000 -> stall=5'b11111, bubble=0.
REQ-034 stop_req pulse, then start_req=2'b00 for 10 cycles, then 2'b10 -> state=HOLD for 10 cycles, stall=5'b11111, hold_cnt=10; state=RUN next edge, hold_cnt=0.
REQ-035 TIMEOUT=3, hold for 6 cycles -> timeout rises on the edge hold_cnt becomes 3, hold_cnt stays 3, timeout clears on start.
REQ-036 FLUSH_CYC=2, flush_req with flush_stage=3 and stop_req in the same cycle, then stop_req during FLUSH -> flush=5'b00111 for 2 cycles, then state=HOLD.
REQ-037 flush_stage=2 then flush_stage=4 one cycle later -> flush=5'b00011, then 5'b01111 for FLUSH_CYC further cycles.
REQ-038 rst asserted during HOLD with timeout=1 -> next edge state=RUN, hold_cnt=0, timeout=0, all outputs 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall/bubble/flush generation
// with a RUN/HOLD/FLUSH state machine and a hold-time watchdog.
module pipe_ctrl #(
  parameter int NSTAGE    = 5,
  parameter int NSTART    = 2,
  parameter int TIMEOUT   = 255,
  parameter int FLUSH_CYC = 1,
  parameter int SW        = (NSTAGE > 1) ? $clog2(NSTAGE) : 1,
  parameter int CW        = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic              stop_req,
  input  logic [NSTART-1:0] start_req,
  input  logic              flush_req,
  input  logic [SW-1:0]     flush_stage,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] bubble,
  output logic [NSTAGE-1:0] flush,
  output logic [1:0]        state,
  output logic [CW-1:0]     hold_cnt,
  output logic              timeout
);

  // Flush down-counter needs at least one bit even when FLUSH_CYC is 1.
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYC - 1);
  localparam logic [CW-1:0] HOLD_MAX   = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   hold_cnt_reg;
  logic            timeout_reg;
  logic [SW-1:0]   f_reg;
  logic [FW-1:0]   fcnt_reg;
  logic            pend_reg;

  logic [NSTAGE-1:0] run_stall;
  logic [NSTAGE-1:0] run_bubble;
  logic [NSTAGE-1:0] flush_mask;

  // Per-stage decode: a stage stalls if it or any older stage stalls; the
  // stage just above the oldest stalled one receives a bubble; stages
  // younger than the latched flush stage are invalidated.
  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
      assign run_stall[gi] = |stall_req[NSTAGE-1:gi];
      if (gi == 0) begin : g_first
        assign run_bubble[gi] = 1'b0;
      end else begin : g_rest
        assign run_bubble[gi] = stall_req[gi-1] & ~run_stall[gi];
      end
      assign flush_mask[gi] = (32'(f_reg) > 32'(gi));
    end
  endgenerate

  // Output selection by state; reset and a same-cycle flush request in RUN
  // suppress the stall/bubble pattern.
  always_comb begin
    stall  = '0;
    bubble = '0;
    flush  = '0;
    if (!rst) begin
      case (state_reg)
        RUN: begin
          if (!flush_req) begin
            stall  = run_stall;
            bubble = run_bubble;
          end
        end
        HOLD:    stall = '1;
        FLUSH:   flush = flush_mask;
        default: ;
      endcase
    end
  end

  // State machine, flush bookkeeping and hold watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
      f_reg        <= '0;
      fcnt_reg     <= '0;
      pend_reg     <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (flush_req) begin
            state_reg <= FLUSH;
            f_reg     <= flush_stage;
            fcnt_reg  <= FLUSH_LOAD;
            pend_reg  <= 1'b0;
          end else if (stop_req) begin
            state_reg    <= HOLD;
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
          end
        end
        HOLD: begin
          if (flush_req) begin
            state_reg    <= FLUSH;
            f_reg        <= flush_stage;
            fcnt_reg     <= FLUSH_LOAD;
            pend_reg     <= 1'b0;
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
          end else if ((|start_req) && !stop_req) begin
            state_reg    <= RUN;
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
          end else if (hold_cnt_reg != HOLD_MAX) begin
            hold_cnt_reg <= hold_cnt_reg + CW'(1);
            timeout_reg  <= (hold_cnt_reg + CW'(1) == HOLD_MAX);
          end
        end
        FLUSH: begin
          if (flush_req) begin
            // Re-flush keeps the widest invalidation window seen so far.
            if (flush_stage > f_reg) begin
              f_reg <= flush_stage;
            end
            fcnt_reg <= FLUSH_LOAD;
            if (stop_req) begin
              pend_reg <= 1'b1;
            end
          end else if (fcnt_reg == '0) begin
            state_reg    <= (pend_reg || stop_req) ? HOLD : RUN;
            pend_reg     <= 1'b0;
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
          end else begin
            fcnt_reg <= fcnt_reg - FW'(1);
            if (stop_req) begin
              pend_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign state    = state_reg;
  assign hold_cnt = hold_cnt_reg;
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the controller.
module tb_pipe_ctrl;

  localparam int NSTAGE    = 5;
  localparam int NSTART    = 2;
  localparam int TIMEOUT   = 12;
  localparam int FLUSH_CYC = 2;
  localparam int SW        = 3;
  localparam int CW        = 4;

  logic              clk;
  logic              rst;
  logic [NSTAGE-1:0] stall_req;
  logic              stop_req;
  logic [NSTART-1:0] start_req;
  logic              flush_req;
  logic [SW-1:0]     flush_stage;
  logic [NSTAGE-1:0] stall;
  logic [NSTAGE-1:0] bubble;
  logic [NSTAGE-1:0] flush;
  logic [1:0]        state;
  logic [CW-1:0]     hold_cnt;
  logic              timeout;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: state as spec value, remaining flush cycles, etc.
  int m_state;
  int m_hc;
  int m_to;
  int m_f;
  int m_left;
  int m_pend;

  pipe_ctrl #(
    .NSTAGE(NSTAGE), .NSTART(NSTART), .TIMEOUT(TIMEOUT), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .stop_req(stop_req),
    .start_req(start_req), .flush_req(flush_req), .flush_stage(flush_stage),
    .stall(stall), .bubble(bubble), .flush(flush), .state(state),
    .hold_cnt(hold_cnt), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_step();
    int p;
    if (rst) begin
      m_state = 0; m_hc = 0; m_to = 0; m_f = 0; m_left = 0; m_pend = 0;
    end else if (m_state == 0) begin
      if (flush_req) begin
        m_state = 2; m_f = int'(flush_stage); m_left = FLUSH_CYC; m_pend = 0;
      end else if (stop_req) begin
        m_state = 1; m_hc = 0; m_to = 0;
      end
    end else if (m_state == 1) begin
      if (flush_req) begin
        m_state = 2; m_f = int'(flush_stage); m_left = FLUSH_CYC; m_pend = 0;
        m_hc = 0; m_to = 0;
      end else if (start_req != 0 && !stop_req) begin
        m_state = 0; m_hc = 0; m_to = 0;
      end else begin
        m_hc = (m_hc + 1 > TIMEOUT) ? TIMEOUT : m_hc + 1;
        m_to = (m_hc == TIMEOUT) ? 1 : 0;
      end
    end else begin
      p = (m_pend != 0 || stop_req) ? 1 : 0;
      if (flush_req) begin
        if (int'(flush_stage) > m_f) m_f = int'(flush_stage);
        m_left = FLUSH_CYC; m_pend = p;
      end else if (m_left == 1) begin
        m_state = (p != 0) ? 1 : 0; m_pend = 0; m_hc = 0; m_to = 0;
      end else begin
        m_left = m_left - 1; m_pend = p;
      end
    end
  endtask

  // Expected combinational outputs from model state and current inputs.
  function automatic void exp_comb(output logic [NSTAGE-1:0] s,
                                   output logic [NSTAGE-1:0] b,
                                   output logic [NSTAGE-1:0] f);
    int h;
    s = '0; b = '0; f = '0;
    if (!rst) begin
      if (m_state == 0 && !flush_req) begin
        h = -1;
        for (int i = 0; i < NSTAGE; i++) if (stall_req[i]) h = i;
        for (int j = 0; j <= h; j++) s[j] = 1'b1;
        if (h >= 0 && h + 1 < NSTAGE) b[h+1] = 1'b1;
      end else if (m_state == 1) begin
        s = '1;
      end else if (m_state == 2) begin
        for (int j = 0; j < NSTAGE; j++) if (j < m_f) f[j] = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    stall_req = '0; stop_req = 0; start_req = '0; flush_req = 0; flush_stage = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; stall_req = 5'b10101;
    #1;
    checks++;
    if (stall !== 5'b0 || bubble !== 5'b0 || flush !== 5'b0) begin
      failures++;
      $display("FAIL reset_comb: stall=%b bubble=%b flush=%b required all 0", stall, bubble, flush);
    end
    tick(); tick();
    rst = 0; stall_req = '0;
    #1;
    checks++;
    if (state !== 2'd0 || hold_cnt !== 4'd0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs: state=%0d hold_cnt=%0d timeout=%b required 0/0/0", state, hold_cnt, timeout);
    end
    $display("test_reset: state=%0d hold_cnt=%0d timeout=%b", state, hold_cnt, timeout);
  endtask

  task automatic test_run_stall();
    logic [NSTAGE-1:0] req [4];
    logic [NSTAGE-1:0] es  [4];
    logic [NSTAGE-1:0] eb  [4];
    req[0] = 5'b00100; es[0] = 5'b00111; eb[0] = 5'b01000;
    req[1] = 5'b10000; es[1] = 5'b11111; eb[1] = 5'b00000;
    req[2] = 5'b00000; es[2] = 5'b00000; eb[2] = 5'b00000;
    req[3] = 5'b00011; es[3] = 5'b00011; eb[3] = 5'b00100;
    for (int i = 0; i < 4; i++) begin
      stall_req = req[i];
      #1;
      checks++;
      if (stall !== es[i] || bubble !== eb[i] || flush !== 5'b0) begin
        failures++;
        $display("FAIL run_stall[%0d]: stall=%b bubble=%b flush=%b required %b/%b/00000",
                 i, stall, bubble, flush, es[i], eb[i]);
      end
      $display("test_run_stall: req=%b stall=%b bubble=%b", req[i], stall, bubble);
      tick();
    end
    stall_req = '0;
  endtask

  task automatic test_hold();
    stop_req = 1;
    tick();
    stop_req = 0;
    for (int i = 1; i <= 10; i++) begin
      stall_req = 5'(i);
      #1;
      checks++;
      if (stall !== 5'b11111 || bubble !== 5'b0) begin
        failures++;
        $display("FAIL hold_stall[%0d]: stall=%b bubble=%b required 11111/00000", i, stall, bubble);
      end
      tick();
      checks++;
      if (state !== 2'd1 || hold_cnt !== 4'(i)) begin
        failures++;
        $display("FAIL hold_cnt[%0d]: state=%0d hold_cnt=%0d required 1/%0d", i, state, hold_cnt, i);
      end
    end
    stall_req = '0; start_req = 2'b10;
    tick();
    start_req = '0;
    checks++;
    if (state !== 2'd0 || hold_cnt !== 4'd0) begin
      failures++;
      $display("FAIL hold_release: state=%0d hold_cnt=%0d required 0/0", state, hold_cnt);
    end
    $display("test_hold: released state=%0d hold_cnt=%0d", state, hold_cnt);
  endtask

  task automatic test_timeout();
    int e;
    stop_req = 1;
    tick();
    stop_req = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      e = (i > TIMEOUT) ? TIMEOUT : i;
      checks++;
      if (hold_cnt !== 4'(e) || timeout !== (i >= TIMEOUT)) begin
        failures++;
        $display("FAIL timeout[%0d]: hold_cnt=%0d timeout=%b required %0d/%b",
                 i, hold_cnt, timeout, e, (i >= TIMEOUT));
      end
    end
    start_req = 2'b01;
    tick();
    start_req = '0;
    checks++;
    if (timeout !== 1'b0 || state !== 2'd0 || hold_cnt !== 4'd0) begin
      failures++;
      $display("FAIL timeout_clear: timeout=%b state=%0d hold_cnt=%0d required 0/0/0", timeout, state, hold_cnt);
    end
    $display("test_timeout: cleared timeout=%b", timeout);
  endtask

  task automatic test_flush_stop();
    stall_req = 5'b00100; flush_req = 1; flush_stage = 3'd3; stop_req = 1;
    #1;
    checks++;
    if (stall !== 5'b0 || bubble !== 5'b0 || flush !== 5'b0) begin
      failures++;
      $display("FAIL flush_override: stall=%b bubble=%b flush=%b required all 0", stall, bubble, flush);
    end
    tick();
    stall_req = '0; flush_req = 0; flush_stage = '0;
    for (int i = 0; i < 2; i++) begin
      stop_req = (i == 0);
      #1;
      checks++;
      if (state !== 2'd2 || flush !== 5'b00111 || stall !== 5'b0) begin
        failures++;
        $display("FAIL flush_stop[%0d]: state=%0d flush=%b stall=%b required 2/00111/00000", i, state, flush, stall);
      end
      tick();
    end
    stop_req = 0;
    #1;
    checks++;
    if (state !== 2'd1 || flush !== 5'b0 || stall !== 5'b11111) begin
      failures++;
      $display("FAIL flush_to_hold: state=%0d flush=%b stall=%b required 1/00000/11111", state, flush, stall);
    end
    $display("test_flush_stop: after flush state=%0d", state);
    start_req = 2'b01;
    tick();
    start_req = '0;
  endtask

  task automatic test_flush_extend();
    flush_req = 1; flush_stage = 3'd2;
    tick();
    flush_stage = 3'd4;
    #1;
    checks++;
    if (flush !== 5'b00011) begin
      failures++;
      $display("FAIL flush_first: flush=%b required 00011", flush);
    end
    tick();
    flush_req = 0; flush_stage = '0;
    for (int i = 0; i < FLUSH_CYC; i++) begin
      #1;
      checks++;
      if (state !== 2'd2 || flush !== 5'b01111) begin
        failures++;
        $display("FAIL flush_ext[%0d]: state=%0d flush=%b required 2/01111", i, state, flush);
      end
      tick();
    end
    checks++;
    if (state !== 2'd0 || flush !== 5'b0) begin
      failures++;
      $display("FAIL flush_exit: state=%0d flush=%b required 0/00000", state, flush);
    end
    $display("test_flush_extend: exit state=%0d", state);
  endtask

  task automatic test_rst_mid_hold();
    stop_req = 1;
    tick();
    stop_req = 0;
    for (int i = 0; i < 13; i++) tick();
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL pre_rst_timeout: timeout=%b required 1", timeout);
    end
    rst = 1;
    #1;
    checks++;
    if (stall !== 5'b0) begin
      failures++;
      $display("FAIL rst_comb_hold: stall=%b required 00000", stall);
    end
    tick();
    rst = 0;
    #1;
    checks++;
    if (state !== 2'd0 || hold_cnt !== 4'd0 || timeout !== 1'b0 ||
        stall !== 5'b0 || bubble !== 5'b0 || flush !== 5'b0) begin
      failures++;
      $display("FAIL rst_mid_hold: state=%0d hold_cnt=%0d timeout=%b stall=%b bubble=%b flush=%b required all 0",
               state, hold_cnt, timeout, stall, bubble, flush);
    end
    $display("test_rst_mid_hold: state=%0d timeout=%b", state, timeout);
  endtask

  task automatic test_random();
    logic [NSTAGE-1:0] es, eb, ef;
    int bad;
    bad = 0;
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 99) < 2);
      stall_req   = 5'($urandom) & 5'($urandom);
      stop_req    = ($urandom_range(0, 99) < 12);
      start_req   = ($urandom_range(0, 99) < 20) ? 2'($urandom) : 2'b00;
      flush_req   = ($urandom_range(0, 99) < 10);
      flush_stage = 3'($urandom_range(0, 7));
      #1;
      exp_comb(es, eb, ef);
      checks++;
      if (stall !== es || bubble !== eb || flush !== ef ||
          state !== 2'(m_state) || hold_cnt !== 4'(m_hc) || timeout !== (m_to != 0)) begin
        failures++; bad++;
        $display("FAIL random[%0d]: stall=%b bubble=%b flush=%b state=%0d hc=%0d to=%b required %b/%b/%b/%0d/%0d/%0d",
                 n, stall, bubble, flush, state, hold_cnt, timeout, es, eb, ef, m_state, m_hc, m_to);
      end
      tick();
    end
    rst = 0;
    idle_inputs();
    $display("test_random: 600 cycles, %0d bad", bad);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_run_stall();
    test_hold();
    test_timeout();
    test_flush_stop();
    test_flush_extend();
    test_rst_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
